// File: rtl/io_port_pkg.sv
// ---------------------------------------------------------------------------
// io_port_pkg
// Shared definitions for the RAT MCU port-mapped I/O controller:
//   - byte_t        : 8-bit port data / port ID type
//   - default IDs   : board peripheral and interrupt-controller port IDs
//   - id_in_range   : membership test for a contiguous ID window
//   - port_ids_ok   : elaboration-time check that the output window, the
//                     input window and the interrupt IDs never collide
// ---------------------------------------------------------------------------
package io_port_pkg;

   typedef logic [7:0] byte_t;

   // Board default port IDs
   localparam byte_t SWITCHES_ID      = 8'h20;
   localparam byte_t LEDS_ID          = 8'h40;
   localparam byte_t SEVSEG_ID        = 8'h81;
   localparam byte_t DEF_INT_MASK_ID  = 8'hF0;
   localparam byte_t DEF_INT_ACK_ID   = 8'hF1;
   localparam byte_t DEF_INT_STAT_ID  = 8'hF2;

   // Number of interrupt sources handled by the controller
   localparam int NUM_IRQ = 8;

   function automatic bit id_in_range(input int id, input int base, input int num);
      return (id >= base) && (id < base + num);
   endfunction

   // True when the two windows fit in the 8-bit ID space, do not overlap,
   // and none of the interrupt-controller IDs lands inside either window.
   function automatic bit port_ids_ok(input int out_base, input int num_out,
                                      input int in_base,  input int num_in,
                                      input int mask_id,  input int ack_id,
                                      input int stat_id);
      bit ok;
      ok = (out_base + num_out <= 256) && (in_base + num_in <= 256);
      if ((out_base < in_base + num_in) && (in_base < out_base + num_out))
         ok = 1'b0;
      if (id_in_range(mask_id, out_base, num_out) || id_in_range(mask_id, in_base, num_in))
         ok = 1'b0;
      if (id_in_range(ack_id, out_base, num_out) || id_in_range(ack_id, in_base, num_in))
         ok = 1'b0;
      if (id_in_range(stat_id, out_base, num_out) || id_in_range(stat_id, in_base, num_in))
         ok = 1'b0;
      if ((mask_id == ack_id) || (mask_id == stat_id) || (ack_id == stat_id))
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/io_sync_edge.sv
// ---------------------------------------------------------------------------
// io_sync_edge
// Two-flop synchroniser followed by a previous-sample flop, producing a
// one-cycle rising-edge pulse per bit. The pulse is formed only from flop
// outputs, so it is glitch-free.
//
// Edges are suppressed until the synchroniser holds post-reset samples:
// a source that is already high when reset releases must not look like a
// fresh edge. While not yet primed, the previous-sample flop tracks the
// first synchroniser stage, so that when primed goes high sync and prev
// already agree.
//
// Ports:
//   i_clk    in   clock
//   i_rst    in   asynchronous active-high reset
//   i_async  in   WIDTH asynchronous inputs
//   o_edge   out  WIDTH one-cycle rising-edge pulses
// ---------------------------------------------------------------------------
module io_sync_edge
   import io_port_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_edge
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_prev;
   logic             r_warm;
   logic             r_primed;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_prev   <= '0;
         r_warm   <= 1'b0;
         r_primed <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_warm   <= 1'b1;
         r_primed <= r_warm;
         // Before priming, run prev one stage ahead so it matches sync
         // on the first primed cycle.
         r_prev   <= r_primed ? r_sync : r_meta;
      end
   end

   assign o_edge = r_sync & ~r_prev & {WIDTH{r_primed}};

endmodule

// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
// Port-mapped I/O controller between the RAT MCU port bus and board
// peripherals: NUM_OUT output registers, NUM_IN synchronised input ports
// and an 8-source edge-triggered interrupt controller.
//
// Build option:
//   IO_PORT_CTRL_READBACK_EN  when defined, reads of the output window return
//                             the stored register; otherwise they return 0
//                             and no readback mux exists.
//
// Ports:
//   i_clk       in   clock, all state on the rising edge
//   i_rst       in   asynchronous active-high reset
//   i_port_id   in   8   MCU port address
//   i_out_port  in   8   MCU write data
//   i_io_strb   in   1   MCU write strobe
//   o_in_port   out  8   read data, combinational from i_port_id
//   i_in_data   in   8*NUM_IN  async inputs, port j at [8j+7:8j]
//   o_out_data  out  8*NUM_OUT output registers, same packing
//   i_int_src   in   8   async interrupt sources, rising-edge sensitive
//   o_int_r     out  1   registered interrupt request
// ---------------------------------------------------------------------------
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter int    NUM_OUT     = 4,
   parameter int    NUM_IN      = 2,
   parameter byte_t OUT_BASE_ID = LEDS_ID,
   parameter byte_t IN_BASE_ID  = SWITCHES_ID,
   parameter byte_t INT_MASK_ID = DEF_INT_MASK_ID,
   parameter byte_t INT_ACK_ID  = DEF_INT_ACK_ID,
   parameter byte_t INT_STAT_ID = DEF_INT_STAT_ID
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_port_id,
   input  logic [7:0]           i_out_port,
   input  logic                 i_io_strb,
   output logic [7:0]           o_in_port,
   input  logic [8*NUM_IN-1:0]  i_in_data,
   output logic [8*NUM_OUT-1:0] o_out_data,
   input  logic [7:0]           i_int_src,
   output logic                 o_int_r
);

   // ---------------------------------------------------------------- checks
   if ((NUM_OUT < 1) || (NUM_OUT > 8) || (NUM_IN < 1) || (NUM_IN > 8)) begin : g_bad_num
      $error("io_port_ctrl: NUM_OUT and NUM_IN must be 1..8");
   end

   if (!port_ids_ok(int'(OUT_BASE_ID), NUM_OUT, int'(IN_BASE_ID), NUM_IN,
                    int'(INT_MASK_ID), int'(INT_ACK_ID), int'(INT_STAT_ID))) begin : g_bad_ids
      $error("io_port_ctrl: port ID windows overlap or contain interrupt IDs");
   end

   // --------------------------------------------------------------- decode
   logic [NUM_OUT-1:0] w_out_sel;
   logic [NUM_IN-1:0]  w_in_sel;
   logic               w_mask_wr;
   logic               w_ack_wr;

   for (genvar gk = 0; gk < NUM_OUT; gk++) begin : g_out_sel
      assign w_out_sel[gk] = (i_port_id == 8'(int'(OUT_BASE_ID) + gk));
   end

   for (genvar gj = 0; gj < NUM_IN; gj++) begin : g_in_sel
      assign w_in_sel[gj] = (i_port_id == 8'(int'(IN_BASE_ID) + gj));
   end

   assign w_mask_wr = i_io_strb && (i_port_id == INT_MASK_ID);
   assign w_ack_wr  = i_io_strb && (i_port_id == INT_ACK_ID);

   // ------------------------------------------------------ output registers
   logic [NUM_OUT-1:0][7:0] r_out;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out <= '0;
      end else if (i_io_strb) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (w_out_sel[k]) r_out[k] <= i_out_port;
         end
      end
   end

   assign o_out_data = r_out;

   // ---------------------------------------------------- input synchroniser
   logic [NUM_IN-1:0][7:0] r_in_meta;
   logic [NUM_IN-1:0][7:0] r_in_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_in_meta <= '0;
         r_in_sync <= '0;
      end else begin
         r_in_meta <= i_in_data;
         r_in_sync <= r_in_meta;
      end
   end

   // ------------------------------------------------- interrupt controller
   logic [NUM_IRQ-1:0] w_int_edge;
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_pend;
   logic [NUM_IRQ-1:0] w_pend_kept;
   logic               r_int;

   io_sync_edge #(
      .WIDTH (NUM_IRQ)
   ) u_int_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_int_src),
      .o_edge  (w_int_edge)
   );

   // Ack clears first, then new edges are OR'd in, so a same-cycle set wins.
   assign w_pend_kept = w_ack_wr ? (r_pend & ~i_out_port) : r_pend;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mask <= '0;
         r_pend <= '0;
         r_int  <= 1'b0;
      end else begin
         if (w_mask_wr) r_mask <= i_out_port;
         r_pend <= w_pend_kept | w_int_edge;
         r_int  <= |(r_pend & r_mask);
      end
   end

   assign o_int_r = r_int;

   // -------------------------------------------------------------- read mux
   logic [7:0] w_rd;

   always_comb begin
      w_rd = 8'h00;
      for (int j = 0; j < NUM_IN; j++) begin
         if (w_in_sel[j]) w_rd = r_in_sync[j];
      end
`ifdef IO_PORT_CTRL_READBACK_EN
      for (int k = 0; k < NUM_OUT; k++) begin
         if (w_out_sel[k]) w_rd = r_out[k];
      end
`endif
      if (i_port_id == INT_MASK_ID) w_rd = r_mask;
      if (i_port_id == INT_STAT_ID) w_rd = r_pend;
   end

   assign o_in_port = w_rd;

endmodule

// File: tb/tb_io_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_port_ctrl
// Directed self-checking bench for io_port_ctrl with default parameters
// (NUM_OUT=4 at 8'h40, NUM_IN=2 at 8'h20, interrupt IDs 8'hF0..8'hF2).
// ---------------------------------------------------------------------------
module tb_io_port_ctrl;

   logic        clk;
   logic        rst;
   logic [7:0]  port_id;
   logic [7:0]  out_port;
   logic        io_strb;
   logic [7:0]  in_port;
   logic [15:0] in_data;
   logic [31:0] out_data;
   logic [7:0]  int_src;
   logic        int_r;

   int n_chk;
   int n_err;

   io_port_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_port_id  (port_id),
      .i_out_port (out_port),
      .i_io_strb  (io_strb),
      .o_in_port  (in_port),
      .i_in_data  (in_data),
      .o_out_data (out_data),
      .i_int_src  (int_src),
      .o_int_r    (int_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] data);
      port_id  = id;
      out_port = data;
      io_strb  = 1'b1;
      tick(1);
      io_strb  = 1'b0;
      port_id  = 8'h00;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] id, input logic [7:0] exp);
      port_id = id;
      #1;
      check(tag, {24'h0, in_port}, {24'h0, exp});
      port_id = 8'h00;
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rst      = 1'b1;
      port_id  = 8'h00;
      out_port = 8'h00;
      io_strb  = 1'b0;
      in_data  = 16'h0000;
      int_src  = 8'hFF;     // held high through reset

      #1;
      check("rst_out_data", out_data, 32'h0);
      check("rst_int_r", {31'h0, int_r}, 32'h0);
      tick(2);

      // Strobe coincident with reset is lost
      wr(8'h42, 8'h77);
      check("rst_strobe_lost", out_data, 32'h0);

      rst = 1'b0;
      tick(10);
      rd_chk("prime_no_pend", 8'hF2, 8'h00);
      check("prime_no_int", {31'h0, int_r}, 32'h0);
      int_src = 8'h00;
      tick(4);

      // Write decode
      wr(8'h41, 8'hA5);
      check("wr_41", out_data, 32'h0000A500);
      wr(8'h44, 8'h5A);
      check("wr_44_ignored", out_data, 32'h0000A500);
      wr(8'h40, 8'h11);
      wr(8'h43, 8'hC3);
      check("wr_40_43", out_data, 32'hC300A511);
      wr(8'h3F, 8'hEE);
      check("wr_3f_ignored", out_data, 32'hC300A511);

`ifdef IO_PORT_CTRL_READBACK_EN
      rd_chk("readback_41", 8'h41, 8'hA5);
`else
      rd_chk("readback_41", 8'h41, 8'h00);
`endif

      // Input synchroniser: visible after two edges
      in_data[7:0] = 8'h3C;
      port_id = 8'h20;
      tick(1);
      check("in_sync_1", {24'h0, in_port}, 32'h0);
      tick(1);
      check("in_sync_2", {24'h0, in_port}, 32'h3C);
      in_data[15:8] = 8'h7E;
      tick(2);
      rd_chk("in_port_21", 8'h21, 8'h7E);
      rd_chk("rd_99", 8'h99, 8'h00);
      rd_chk("rd_22", 8'h22, 8'h00);

      // Interrupt flow, unmasked bit 0
      wr(8'hF0, 8'h01);
      rd_chk("mask_rd", 8'hF0, 8'h01);
      int_src = 8'h01;
      tick(3);
      check("irq_lat_3", {31'h0, int_r}, 32'h0);
      tick(1);
      check("irq_lat_4", {31'h0, int_r}, 32'h1);
      rd_chk("stat_01", 8'hF2, 8'h01);
      wr(8'hF1, 8'h01);
      rd_chk("ack_stat", 8'hF2, 8'h00);
      check("ack_int_hold", {31'h0, int_r}, 32'h1);
      tick(1);
      check("ack_int_clr", {31'h0, int_r}, 32'h0);

      // Masked pending, then enabling the mask
      wr(8'hF0, 8'h00);
      int_src = 8'h09;
      tick(5);
      rd_chk("masked_stat", 8'hF2, 8'h08);
      check("masked_no_int", {31'h0, int_r}, 32'h0);
      wr(8'hF0, 8'h08);
      check("mask_wr_1", {31'h0, int_r}, 32'h0);
      tick(1);
      check("mask_wr_2", {31'h0, int_r}, 32'h1);

      // Ack and new edge on bit 3 in the same cycle: set wins
      int_src = 8'h01;
      tick(4);
      int_src = 8'h09;
      tick(2);
      wr(8'hF1, 8'h08);
      rd_chk("collide_stat", 8'hF2, 8'h08);
      tick(1);
      check("collide_int", {31'h0, int_r}, 32'h1);

      // Mid-operation asynchronous reset
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out", out_data, 32'h0);
      check("mid_rst_int", {31'h0, int_r}, 32'h0);
      rd_chk("mid_rst_mask", 8'hF0, 8'h00);
      rd_chk("mid_rst_stat", 8'hF2, 8'h00);
      rd_chk("mid_rst_in", 8'h20, 8'h00);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
